// File: rtl/beam_sum_i2s_tx.sv
// beam_sum_i2s_tx: averages one delayed sample per channel into a delay-and-sum
// beam word and serialises it on an I2S link, repeating the word in both halves.
module beam_sum_i2s_tx #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int NUM_CHANNELS   = 2,
    parameter int WS_HALF_PERIOD = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CHANNELS*NUMBER_OF_BITS-1:0] sample_in,
    input  logic                                   sample_valid,
    output logic                                   sd_out,
    output logic                                   ws_out,
    output logic                                   overrun,
    output logic                                   underrun
);
    localparam int N     = NUMBER_OF_BITS;
    localparam int LOG2C = $clog2(NUM_CHANNELS);
    localparam int SW    = N + LOG2C;
    localparam int H     = WS_HALF_PERIOD;
    localparam int SLOTS = 2 * H;
    localparam int CW    = $clog2(SLOTS);

    // Sign-extended sum of all channels, floor-divided by the channel count.
    function automatic logic [N-1:0] beam_average(input logic [NUM_CHANNELS*N-1:0] samples);
        logic signed [N-1:0]  chan;
        logic signed [SW-1:0] acc;
        logic signed [SW-1:0] shifted;
        acc = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            chan = samples[k*N +: N];
            acc  = acc + SW'(chan);
        end
        shifted = acc >>> LOG2C;
        return shifted[N-1:0];
    endfunction

    logic [CW-1:0] slot_r;
    logic [CW-1:0] slot_next_s;
    logic [CW-1:0] pos_next_s;
    logic          wrap_s;
    logic          ws_next_s;
    logic          sd_next_s;
    logic [N-1:0]  word_r;
    logic [N-1:0]  pending_r;
    logic [N-1:0]  avg_s;
    logic [N-1:0]  word_shift_s;
    logic          pending_full_r;
    logic          seen_first_r;

    // Next slot, its half-frame position, and the serial bit that position selects.
    always_comb begin
        slot_next_s = (slot_r == CW'(SLOTS - 1)) ? '0 : slot_r + CW'(1);
        wrap_s      = (slot_next_s == '0);
        ws_next_s   = (slot_next_s >= CW'(H));
        if (ws_next_s) begin
            pos_next_s = slot_next_s - CW'(H);
        end else begin
            pos_next_s = slot_next_s;
        end
        // Position 0 is the I2S one-bit delay; the word is already loaded by then.
        word_shift_s = word_r >> (CW'(N) - pos_next_s);
        if ((pos_next_s >= CW'(1)) && (pos_next_s <= CW'(N))) begin
            sd_next_s = word_shift_s[0];
        end else begin
            sd_next_s = 1'b0;
        end
        avg_s = beam_average(sample_in);
    end

    // Frame timing, sample capture, frame load and sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_r         <= '0;
            ws_out         <= 1'b0;
            sd_out         <= 1'b0;
            word_r         <= '0;
            pending_r      <= '0;
            pending_full_r <= 1'b0;
            seen_first_r   <= 1'b0;
            overrun        <= 1'b0;
            underrun       <= 1'b0;
        end else begin
            slot_r <= slot_next_s;
            ws_out <= ws_next_s;
            sd_out <= sd_next_s;
            if (wrap_s && pending_full_r) begin
                word_r       <= pending_r;
                seen_first_r <= 1'b1;
            end
            if (wrap_s && !pending_full_r && seen_first_r) begin
                underrun <= 1'b1;
            end
            // A strobe on the load edge refills pending after it was consumed.
            if (sample_valid) begin
                pending_r      <= avg_s;
                pending_full_r <= 1'b1;
                if (pending_full_r && !wrap_s) begin
                    overrun <= 1'b1;
                end
            end else if (wrap_s) begin
                pending_full_r <= 1'b0;
            end
        end
    end
endmodule
